protocol_tx: RTL and testbench
==============================

Name: protocol_tx

Overview:
- SPI master that serialises one complete frame in the lamp SPI frame format: header, then all channel words.
- It is the transmit end of the lamp SPI slave interface (i_dck/i_cs/i_mosi). It drives the lamp from a host-side FPGA and is also the stimulus engine for lamp-level loopback benches.
- Channel data is read from a framebuffer-style RAM: synchronous read, 1-cycle latency.

Parameters:
- c_ledboards, 30, number of LED boards; c_channels = c_ledboards*32.
- c_bpc, 12, bits per channel word.
- c_max_time, 1024, time field range; c_time_w = $clog2(c_max_time).
- c_max_type, 64, type field range; c_type_w = $clog2(c_max_type).
- c_half, 2, i_clk cycles per dck half-period; minimum legal value is 2.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  single-cycle request to send one frame.
- i_time  in  c_time_w  animation time; sampled when i_start is accepted.
- i_type  in  c_type_w  animation type; sampled when i_start is accepted.
- o_busy  out  1  high from the cycle after acceptance until o_done.
- o_done  out  1  one-cycle pulse when the frame is complete.
- o_raddr  out  $clog2(c_channels)  channel read address.
- i_rdata  in  c_bpc  channel word; valid 1 cycle after o_raddr.
- o_dck  out  1  SPI clock; idle low, SPI mode 0.
- o_cs  out  1  chip select; active-low, idle high.
- o_mosi  out  1  serial data, MSB first.

Behaviour:
- Reset values: o_cs=1, o_dck=0, o_mosi=0, o_busy=0, o_done=0, o_raddr=0.
- Frame bit order:
  - header = {type, time}, c_type_w+c_time_w bits (16 by default), MSB first;
  - then channel 0..c_channels-1, each c_bpc bits, MSB first;
  - total 16+960*12 = 11536 bits at defaults.
- Bit timing:
  - mosi is updated in the cycle dck goes low (or at SETUP entry for bit 0);
  - dck stays low for c_half cycles, then high for c_half cycles;
  - the slave samples on the rising edge;
  - dck is contiguous across the header/data and word/word boundaries, with no stretched low phases.
- States:
  - IDLE: o_cs=1. If i_start: latch time/type into a header shift register, set o_raddr=0, go SETUP. i_start in any other state is ignored.
  - SETUP: o_cs=0, o_dck=0, mosi=header MSB, hold c_half cycles, go HDR.
  - HDR: shift the header bits. At the first cycle of the header's last bit low phase, the word for o_raddr is already fetched (issued in SETUP) and latched into a word prefetch register. After the last header bit's high phase, load the shift register from the prefetch register and go DATA.
  - DATA: shift c_bpc bits per word. At the start of each word's last bit, o_raddr increments and the next i_rdata is latched one cycle later into the prefetch register. After the high phase of the last bit of word c_channels-1, go HOLD.
  - HOLD: dck=0, cs=0, for c_half cycles; then cs=1, go GAP.
  - GAP: cs=1 for 2*c_half cycles (minimum deselect time). At the end of GAP: o_done=1 for 1 cycle, o_busy=0, go IDLE. A new i_start is accepted in the cycle after o_done.
- Address wrap: o_raddr does not increment past c_channels-1. It returns to 0 on entry to IDLE.
- Counters:
  - bit counter width $clog2(max(header width, c_bpc))+1;
  - phase counter width $clog2(c_half).
- Frame length in i_clk cycles = c_half*(2*11536+1+1+2) at defaults; 46152 for c_half=2.
- Reset mid-frame: from the next cycle, o_cs=1, o_dck=0, o_mosi=0, busy=0, and no o_done pulse is produced.
- i_start coincident with i_rst: reset wins.

Decomposition:
- Shared package lamp_pkg holds:
  - c_ledboards, c_bpc, c_max_time, c_max_type defaults;
  - derived widths c_addr_w, c_time_w, c_type_w and header width;
  - the state enum shared with the receive side for bench decoding.
- One natural sub-module: spi_bitclk, the phase counter generating dck and shift/edge strobes from c_half. It is reusable by a future readback path.

Test Plan:
- Header only: i_type=6'h2A, i_time=10'h155, RAM all-zero -> capture first 16 rising-edge bits = 16'hA955; all following 11520 bits are 0; o_done pulses exactly once, 46152 cycles after acceptance.
- Data ordering: RAM[n]=n[11:0] -> bench SPI slave model decodes words 0..959 equal to their index; channel 959 = 12'h3BF; o_raddr never exceeds 959.
- Timing: c_half=2 -> every dck high and low phase is exactly 2 cycles; cs falls 2 cycles before the first rising edge and rises 2 cycles after the last falling edge; cs stays high for 4 cycles before o_done.
- Ignored start: pulse i_start at cycle 100 and cycle 20000 of a frame -> exactly one frame is sent; o_busy stays high throughout; only one o_done.
- Reset mid-frame: assert i_rst at bit 5000 -> next cycle o_cs=1, o_dck=0, o_mosi=0, o_busy=0; no o_done; a following i_start sends a complete, correct frame.
- Loopback: connect to lamp with the protocol receiver, send RAM pattern 12'hFFF/12'h000 alternating -> the receiver writes 960 words matching the pattern, with time/type matching.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared lamp SPI frame geometry and the frame state encoding used by both
// the transmit and receive ends of the link.
package lamp_pkg;

    localparam int c_ledboards = 30;
    localparam int c_channels  = c_ledboards * 32;
    localparam int c_bpc       = 12;
    localparam int c_max_time  = 1024;
    localparam int c_max_type  = 64;

    localparam int c_time_w = $clog2(c_max_time);
    localparam int c_type_w = $clog2(c_max_type);
    localparam int c_hdr_w  = c_type_w + c_time_w;
    localparam int c_addr_w = $clog2(c_channels);

    // One shift register serves both the header and the channel words.
    localparam int c_sh_w  = (c_hdr_w > c_bpc) ? c_hdr_w : c_bpc;
    localparam int c_cnt_w = $clog2(c_sh_w) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HDR,
        ST_DATA,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } lamp_state_e;

endpackage

// File: rtl/spi_bitclk.sv
// Half-period phase counter producing the SPI bit clock level plus one-cycle
// strobes flagging the last cycle before each rising and falling edge.
module spi_bitclk #(
    parameter int c_half = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_dck,
    output logic o_rise,
    output logic o_fall
);

    localparam int c_ph_w = (c_half > 1) ? $clog2(c_half) : 1;
    localparam logic [c_ph_w-1:0] c_ph_last = c_ph_w'(c_half - 1);

    logic [c_ph_w-1:0] ph_q, ph_d;
    logic              dck_q, dck_d;
    logic              wrap;

    assign wrap   = (ph_q == c_ph_last);
    assign o_dck  = dck_q;
    assign o_rise = i_en && wrap && !dck_q;
    assign o_fall = i_en && wrap && dck_q;

    // Disabled means parked at the start of a low phase, ready for bit 0.
    always_comb begin
        ph_d  = ph_q;
        dck_d = dck_q;
        if (!i_en) begin
            ph_d  = '0;
            dck_d = 1'b0;
        end else if (wrap) begin
            ph_d  = '0;
            dck_d = !dck_q;
        end else begin
            ph_d = ph_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ph_q  <= '0;
            dck_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            dck_q <= dck_d;
        end
    end

endmodule

// File: rtl/protocol_tx.sv
// SPI master sending one lamp frame: {type, time} header followed by every
// channel word read from a synchronous framebuffer RAM, all MSB first.
module protocol_tx
    import lamp_pkg::*;
#(
    parameter int c_half = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [c_time_w-1:0] i_time,
    input  logic [c_type_w-1:0] i_type,
    output logic                o_busy,
    output logic                o_done,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bpc-1:0]    i_rdata,
    output logic                o_dck,
    output logic                o_cs,
    output logic                o_mosi
);

    localparam int c_hdr_pad = c_sh_w - c_hdr_w;
    localparam int c_bpc_pad = c_sh_w - c_bpc;
    localparam logic [c_cnt_w-1:0]  c_hdr_last  = c_cnt_w'(c_hdr_w - 1);
    localparam logic [c_cnt_w-1:0]  c_hdr_pen   = c_cnt_w'(c_hdr_w - 2);
    localparam logic [c_cnt_w-1:0]  c_bpc_last  = c_cnt_w'(c_bpc - 1);
    localparam logic [c_cnt_w-1:0]  c_bpc_pen   = c_cnt_w'(c_bpc - 2);
    localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);

    lamp_state_e         state_q, state_d;
    logic [c_sh_w-1:0]   shift_q, shift_d;
    logic [c_cnt_w-1:0]  bit_q, bit_d;
    logic [c_addr_w-1:0] raddr_q, raddr_d;
    logic [c_bpc-1:0]    pf_q, pf_d;
    logic                fetch1_q, fetch1_d;
    logic                fetch2_q, fetch2_d;
    logic                last_q, last_d;
    logic                bc_en, bc_dck, bc_rise, bc_fall;
    logic [c_sh_w-1:0]   word_load;

    // The bit clock keeps running through HOLD and GAP to time them; dck is
    // only shown on the pin while bits are actually being shifted.
    assign bc_en = state_q inside {ST_SETUP, ST_HDR, ST_DATA, ST_HOLD, ST_GAP};

    spi_bitclk #(
        .c_half (c_half)
    ) u_bitclk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (bc_en),
        .o_dck  (bc_dck),
        .o_rise (bc_rise),
        .o_fall (bc_fall)
    );

    assign word_load = c_sh_w'(pf_q) << c_bpc_pad;

    assign o_busy  = !(state_q inside {ST_IDLE, ST_DONE});
    assign o_done  = (state_q == ST_DONE);
    assign o_raddr = raddr_q;
    assign o_cs    = !(state_q inside {ST_SETUP, ST_HDR, ST_DATA, ST_HOLD});
    assign o_dck   = bc_dck && (state_q inside {ST_HDR, ST_DATA});
    assign o_mosi  = (state_q inside {ST_SETUP, ST_HDR, ST_DATA}) ? shift_q[c_sh_w-1] : 1'b0;

    // A fetch is requested as the final bit of a field begins; the RAM answers
    // two cycles later, well before that bit's high phase ends.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        raddr_d  = raddr_q;
        pf_d     = pf_q;
        fetch1_d = 1'b0;
        fetch2_d = fetch1_q;
        last_d   = last_q;

        if (fetch2_q) begin
            pf_d = i_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                raddr_d = '0;
                bit_d   = '0;
                last_d  = 1'b0;
                if (i_start) begin
                    shift_d = c_sh_w'({i_type, i_time}) << c_hdr_pad;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bc_rise) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (bc_fall) begin
                    if (bit_q == c_hdr_last) begin
                        shift_d = word_load;
                        bit_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == c_hdr_pen) begin
                            fetch1_d = 1'b1;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (bc_fall) begin
                    if (bit_q == c_bpc_last) begin
                        if (last_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            shift_d = word_load;
                            bit_d   = '0;
                        end
                    end else begin
                        shift_d = shift_q << 1;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == c_bpc_pen) begin
                            fetch1_d = 1'b1;
                            if (raddr_q == c_addr_last) begin
                                last_d = 1'b1;
                            end else begin
                                raddr_d = raddr_q + 1'b1;
                            end
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (bc_rise) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (bc_rise) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                raddr_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bit_q    <= '0;
            raddr_q  <= '0;
            pf_q     <= '0;
            fetch1_q <= 1'b0;
            fetch2_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            raddr_q  <= raddr_d;
            pf_q     <= pf_d;
            fetch1_q <= fetch1_d;
            fetch2_q <= fetch2_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_protocol_tx.sv
// Bench for protocol_tx: a slave-side monitor captures the serial stream and
// timing, which is compared against a bit-list model of the lamp frame.
module tb_protocol_tx;
    import lamp_pkg::*;

    localparam int c_half      = 2;
    localparam int c_nbits     = c_hdr_w + c_channels * c_bpc;
    localparam int c_exp_frame = c_half * (2 * c_nbits + 1 + 1 + 2);
    localparam int c_budget    = c_exp_frame + 1000;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [c_time_w-1:0] tm;
    logic [c_type_w-1:0] ty;
    logic                busy, done, dck, cs, mosi;
    logic [c_addr_w-1:0] raddr;
    logic [c_bpc-1:0]    rdata;

    logic [c_bpc-1:0] ram [0:c_channels-1];
    logic             exp_bits [$];
    logic             cap [$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic mon_clear;
    int   phase_err = 0, done_count = 0, busy_count = 0, gap_cnt = 0, gap_len = 0, run_len = 0;
    int   raddr_max = 0;
    logic prev_cs = 1'b1, prev_dck = 1'b0;

    int                  acc_cycle, done_cycle, bit_err, base;
    logic                seen_done, reached;
    logic [c_time_w-1:0] t_a, t_b;
    logic [c_type_w-1:0] y_a, y_b;
    logic [c_hdr_w-1:0]  hdr_got;
    logic [c_bpc-1:0]    word_got;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdata <= ram[raddr];

    protocol_tx #(
        .c_half (c_half)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_time  (tm),
        .i_type  (ty),
        .o_busy  (busy),
        .o_done  (done),
        .o_raddr (raddr),
        .i_rdata (rdata),
        .o_dck   (dck),
        .o_cs    (cs),
        .o_mosi  (mosi)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [c_time_w-1:0] t, input logic [c_type_w-1:0] y, output int acc);
        @(negedge clk);
        tm    = t;
        ty    = y;
        start = 1'b1;
        acc   = cyc;
    endtask

    // Expected frame as a flat list of bits in wire order.
    task automatic buildModel(input logic [c_hdr_w-1:0] hdr);
        exp_bits.delete();
        for (int i = c_hdr_w - 1; i >= 0; i--) exp_bits.push_back(hdr[i]);
        for (int ch = 0; ch < c_channels; ch++)
            for (int b = c_bpc - 1; b >= 0; b--) exp_bits.push_back(ram[ch][b]);
    endtask

    // Slave-side monitor: samples once per cycle, captures mosi on each dck
    // rise, and measures every dck phase that occurs while cs is low.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_clear) begin
                cap.delete();
                phase_err = 0; done_count = 0; busy_count = 0;
                gap_cnt = 0; gap_len = 0; run_len = 0; raddr_max = 0;
                prev_cs = 1'b1; prev_dck = 1'b0;
            end else begin
                if (busy) busy_count++;
                if (done) begin
                    done_count++;
                    gap_len = gap_cnt;
                end
                if (cs && busy) gap_cnt++;
                else if (!cs) gap_cnt = 0;
                if (int'(raddr) > raddr_max) raddr_max = int'(raddr);
                if (!cs) begin
                    if (prev_cs) begin
                        run_len = 1;
                        if (dck) phase_err++;
                    end else if (dck != prev_dck) begin
                        if (run_len != c_half) phase_err++;
                        run_len = 1;
                        if (dck) cap.push_back(mosi);
                    end else begin
                        run_len++;
                    end
                end else if (!prev_cs) begin
                    if (run_len != c_half || prev_dck) phase_err++;
                end
                prev_cs  = cs;
                prev_dck = dck;
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; tm = '0; ty = '0; mon_clear = 1'b1;
        seen_done = 1'b0; done_cycle = 0; acc_cycle = 0;
        for (int ch = 0; ch < c_channels; ch++) ram[ch] = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetCs", 32'(cs), 32'd1);
        checkOutput("resetDck", 32'(dck), 32'd0);
        checkOutput("resetMosi", 32'(mosi), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetRaddr", 32'(raddr), 32'd0);
        rst = 1'b0;
        mon_clear = 1'b0;

        // Frame A is cut short by a reset that coincides with a start request.
        t_a = c_time_w'($urandom);
        y_a = c_type_w'($urandom);
        applyStimulus(t_a, y_a, acc_cycle);
        reached = 1'b0;
        for (int n = 1; n <= 6000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cap.size() >= 300) begin
                reached = 1'b1;
                break;
            end
        end
        checkOutput("resetPointReached", 32'(reached), 32'd1);
        hdr_got = '0;
        if (cap.size() >= c_hdr_w)
            for (int i = 0; i < c_hdr_w; i++) hdr_got = {hdr_got[c_hdr_w-2:0], cap[i]};
        checkOutput("headerFrameA", 32'(hdr_got), 32'({y_a, t_a}));
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("midResetCs", 32'(cs), 32'd1);
        checkOutput("midResetDck", 32'(dck), 32'd0);
        checkOutput("midResetMosi", 32'(mosi), 32'd0);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("startDuringReset", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("noDoneAfterReset", 32'(done_count), 32'd0);

        // Frame B runs to completion with random RAM contents and two
        // start pulses that must be ignored.
        mon_clear = 1'b1;
        for (int ch = 0; ch < c_channels; ch++) ram[ch] = c_bpc'($urandom);
        ram[c_channels-1] = 12'h3BF;
        t_b = c_time_w'($urandom);
        y_b = c_type_w'($urandom);
        buildModel({y_b, t_b});
        repeat (2) @(negedge clk);
        mon_clear = 1'b0;
        applyStimulus(t_b, y_b, acc_cycle);
        for (int n = 1; n <= c_budget; n++) begin
            @(negedge clk);
            start = (n == 100 || n == 20000);
            if (start) begin
                tm = c_time_w'($urandom);
                ty = c_type_w'($urandom);
                checkOutput("busyAtIgnoredStart", 32'(busy), 32'd1);
            end
            if (done) begin
                done_cycle = cyc;
                seen_done  = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checkOutput("frameDone", 32'(seen_done), 32'd1);
        checkOutput("frameLatency", 32'(done_cycle - acc_cycle + 1), 32'(c_exp_frame));
        @(negedge clk);
        checkOutput("afterDoneBusy", 32'(busy), 32'd0);
        checkOutput("afterDoneCs", 32'(cs), 32'd1);
        checkOutput("afterDoneRaddr", 32'(raddr), 32'd0);
        repeat (8) @(negedge clk);
        checkOutput("doneOnce", 32'(done_count), 32'd1);
        checkOutput("busyCycles", 32'(busy_count), 32'(c_exp_frame - 2));
        checkOutput("bitCount", 32'(cap.size()), 32'(c_nbits));
        bit_err = 0;
        for (int i = 0; i < c_nbits && i < cap.size(); i++)
            if (cap[i] !== exp_bits[i]) bit_err++;
        checkOutput("bitStream", 32'(bit_err), 32'd0);
        hdr_got = '0;
        if (cap.size() >= c_hdr_w)
            for (int i = 0; i < c_hdr_w; i++) hdr_got = {hdr_got[c_hdr_w-2:0], cap[i]};
        checkOutput("headerFrameB", 32'(hdr_got), 32'({y_b, t_b}));
        word_got = '0;
        base = c_hdr_w + (c_channels - 1) * c_bpc;
        if (cap.size() >= c_nbits)
            for (int i = 0; i < c_bpc; i++) word_got = {word_got[c_bpc-2:0], cap[base+i]};
        checkOutput("lastChannel", 32'(word_got), 32'h3BF);
        checkOutput("raddrMax", 32'(raddr_max), 32'(c_channels - 1));
        checkOutput("phaseLengths", 32'(phase_err), 32'd0);
        checkOutput("deselectGap", 32'(gap_len), 32'(2 * c_half));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
